fp_div: RTL and testbench
=========================

# fp_div

Sequential IEEE-754 single-precision divider: the inverse of the FPU's combinational multiplier, completing the multiply/divide pair of the floating point ALU. It accepts two 32-bit operands on a start pulse and runs a restoring mantissa division, one quotient bit per clock. It normalises and rounds the result, then presents it with overflow/underflow/divide-by-zero flags and a one-cycle done pulse. Special-case encoding matches the multiplier, so the ALU result mux treats both units identically.

## Interface
Parameters: none. Widths are fixed by the single-precision format.
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high; one clock
- start  input  1  request; sampled only while busy=0
- a  input  32  dividend, IEEE-754 single
- b  input  32  divisor, IEEE-754 single
- busy  output  1  high from the edge after accept until the edge that raises done
- done  output  1  one-cycle pulse; result and flags valid and held until the next accept
- result  output  32  quotient
- overflow  output  1  exponent overflow or divide-by-zero
- underflow  output  1  exponent underflow
- div_by_zero  output  1  b is zero and a is finite non-zero

## Operation
- Reset: state IDLE; busy, done, result, overflow, underflow and div_by_zero all 0.
- Accept: an edge with start=1 and busy=0 latches a and b. Otherwise start is ignored.
- sign = a[31]^b[31].
- Exponent field 0 means zero: subnormals flush to zero. Exponent field 8'hFF means exception.
- Priority:
  1. Either operand is exception → result 32'd0, all flags 0.
  2. b is zero and a is non-zero → {sign,8'hFF,23'd0}, overflow=1, div_by_zero=1.
  3. a is zero (including a=0 with b=0) → {sign,31'd0}, no flags.
  4. Otherwise, divide.
- Divide:
  - ma={1,a[22:0]}, mb={1,b[22:0]}; 25-bit remainder r initialised to ma.
  - 26 steps. Each step: q bit = (r ≥ mb); if set, r -= mb; then r <<= 1. Bits fill q[25] down to q[0].
  - q[25]=1: mant=q[24:2], guard=q[1], e = ea−eb+127.
  - q[25]=0: mant=q[23:1], guard=q[0], e = ea−eb+126.
  - Rounding is round-half-up: mant += guard. A carry out of mant sets mant=0 and e+=1.
- Exponent arithmetic is 10-bit signed.
  - e ≥ 255 → {sign,8'hFF,23'd0}, overflow=1.
  - e ≤ 0 → {sign,31'd0}, underflow=1.
  - Otherwise → {sign,e[7:0],mant}.
- FSM:
  - IDLE → SPECIAL on an accept where case 1, 2 or 3 applies.
  - IDLE → DIVIDE on any other accept.
  - DIVIDE holds for 26 cycles on a 5-bit step counter, then → NORM.
  - NORM → IDLE; this edge registers result and flags and sets done.
  - SPECIAL → IDLE; this edge registers result and flags and sets done.
- result and flags are registered and stable from the done cycle until the edge that accepts the next operation. That accept clears all flags.

## Timing
- Accept at edge k.
- Normal path: DIVIDE steps occupy edges k+1..k+26; NORM at edge k+27. done is high in the cycle after edge k+27. Latency 27 clocks.
- Special path: result registered at edge k+1, done high in the following cycle. Latency 1 clock.
- busy=1 from after edge k until the edge that asserts done; busy=0 while done=1.
- Back-to-back: start may be high during the done cycle. It is accepted there, and done drops at that same edge.
- rst mid-operation: the operation is aborted and no done is produced. The next cycle is IDLE with all outputs 0.
- start=1 together with rst=1: rst wins, the request is lost.

## Structure
- Shared package fp_pkg:
  - Constants: EXP_W=8, MAN_W=23, BIAS=127, EXP_INF=8'hFF.
  - fp_div_state_t enum: IDLE, SPECIAL, DIVIDE, NORM.
- Sub-module fp_div_step: combinational single restoring step.
  - Inputs: r, mb.
  - Outputs: q_bit, r_next.
  - Instantiated once in fp_div; fp_div owns the remainder, quotient and counter registers.
- Top-level FSM, special-case decode and normalise/round live in fp_div.

## Test plan
- a=0x40C00000 (6.0), b=0x40000000 (2.0) → result=0x40400000, flags 0, done exactly 27 clocks after the accept edge.
- a=0x3F800000, b=0x40400000 (1/3) → result=0x3EAAAAAB (rounded up).
- a=0xC0C00000 (−6.0), b=0x40000000 → result=0xC0400000.
- a=0x3F800000, b=0x00000000 → result=0x7F800000, overflow=1, div_by_zero=1, latency 1.
- a=0x7F000000, b=0x00800000 → result=0x7F800000, overflow=1.
- a=0x00800000, b=0x7F000000 → result=0x00000000, underflow=1.
- a=0x7F800000, b=any → result=0x00000000, no flags, latency 1.
- start re-asserted while busy → ignored.
- rst at step 10 → no done, outputs 0.
- Back-to-back accept in the done cycle → second operation completes 27 clocks later.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision constants, divider state encoding and the special-case
// decode used by fp_div.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;
   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

   typedef enum logic [1:0] {IDLE, SPECIAL, DIVIDE, NORM} fp_div_state_t;

   typedef struct packed {
      logic [31:0] result;
      logic        ovf;
      logic        dbz;
   } fp_special_t;

   // Exception operands, a zero divisor, or a zero dividend bypass the divider.
   function automatic logic fp_is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == EXP_INF) || (b[30:23] == EXP_INF) ||
             (a[30:23] == '0) || (b[30:23] == '0);
   endfunction

   function automatic fp_special_t fp_special_result(input logic [31:0] a, input logic [31:0] b);
      fp_special_t res;
      logic        sign;
      sign = a[31] ^ b[31];
      res  = '0;
      if ((a[30:23] == EXP_INF) || (b[30:23] == EXP_INF)) begin
         res = '0;
      end else if (b[30:23] == '0 && a[30:23] != '0) begin
         res.result = {sign, EXP_INF, {MAN_W{1'b0}}};
         res.ovf    = 1'b1;
         res.dbz    = 1'b1;
      end else begin
         res.result = {sign, 31'd0};
      end
      return res;
   endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp_div_step
   import fp_pkg::*;
(
   input  logic [24:0] r,
   input  logic [23:0] mb,
   output logic        q_bit,
   output logic [24:0] r_next
);

   always_comb begin
      q_bit  = (r >= {1'b0, mb});
      r_next = q_bit ? ((r - {1'b0, mb}) << 1) : (r << 1);
   end

endmodule

// File: rtl/fp_div.sv
// Sequential single-precision divider: one quotient bit per clock, then
// normalise/round, with special operands resolved in a single cycle.
module fp_div
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow,
   output logic        div_by_zero
);

   fp_div_state_t state_q, state_d;

   logic             sign_q, sign_d;
   logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
   logic [23:0]      mb_q, mb_d;
   logic [24:0]      r_q, r_d;
   logic [25:0]      quo_q, quo_d;
   logic [4:0]       cnt_q, cnt_d;
   fp_special_t      sp_q, sp_d;
   logic [31:0]      result_q, result_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d, done_q, done_d;

   logic        q_bit;
   logic [24:0] r_next;
   logic        accept;

   logic [9:0]  e_base, e_fin;
   logic [22:0] mant_raw;
   logic        guard;
   logic [23:0] mant_rnd;

   fp_div_step u_step (
      .r      (r_q),
      .mb     (mb_q),
      .q_bit  (q_bit),
      .r_next (r_next)
   );

   assign accept = start && (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = fp_is_special(a, b) ? SPECIAL : DIVIDE;
         DIVIDE:  if (cnt_q == 5'd25) state_d = NORM;
         NORM:    state_d = IDLE;
         SPECIAL: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Normalise on the leading quotient bit, round half-up, rebias exponent.
   always_comb begin
      e_base   = {2'b00, ea_q} - {2'b00, eb_q} + (quo_q[25] ? 10'(BIAS) : 10'(BIAS - 1));
      mant_raw = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
      guard    = quo_q[25] ? quo_q[1] : quo_q[0];
      mant_rnd = {1'b0, mant_raw} + {23'd0, guard};
      e_fin    = e_base + {9'd0, mant_rnd[23]};
   end

   always_comb begin
      sign_d   = sign_q;
      ea_d     = ea_q;
      eb_d     = eb_q;
      mb_d     = mb_q;
      r_d      = r_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      sp_d     = sp_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      dbz_d    = dbz_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sign_d = a[31] ^ b[31];
               ea_d   = a[30:23];
               eb_d   = b[30:23];
               mb_d   = {1'b1, b[22:0]};
               r_d    = {2'b01, a[22:0]};
               quo_d  = '0;
               cnt_d  = '0;
               sp_d   = fp_special_result(a, b);
               ovf_d  = 1'b0;
               unf_d  = 1'b0;
               dbz_d  = 1'b0;
            end
         end
         DIVIDE: begin
            r_d   = r_next;
            quo_d = {quo_q[24:0], q_bit};
            cnt_d = cnt_q + 5'd1;
         end
         NORM: begin
            done_d = 1'b1;
            if ($signed(e_fin) >= 10'sd255) begin
               result_d = {sign_q, EXP_INF, {MAN_W{1'b0}}};
               ovf_d    = 1'b1;
            end else if ($signed(e_fin) <= 10'sd0) begin
               result_d = {sign_q, 31'd0};
               unf_d    = 1'b1;
            end else begin
               result_d = {sign_q, e_fin[7:0], mant_rnd[22:0]};
            end
         end
         SPECIAL: begin
            done_d   = 1'b1;
            result_d = sp_q.result;
            ovf_d    = sp_q.ovf;
            dbz_d    = sp_q.dbz;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q   <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         mb_q     <= '0;
         r_q      <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         sp_q     <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         sign_q   <= sign_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         mb_q     <= mb_d;
         r_q      <= r_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         sp_q     <= sp_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         dbz_q    <= dbz_d;
         done_q   <= done_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign result      = result_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_fp_div;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] a, b;
   logic        busy, done, overflow, underflow, div_by_zero;
   logic [31:0] result;

   fp_div dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .overflow    (overflow),
      .underflow   (underflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        ov;
      logic        un;
      logic        dz;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("overflow", 32'(overflow), 32'(e.ov));
            chk("underflow", 32'(underflow), 32'(e.un));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("busy_in_done", 32'(busy), 32'd0);
            $display("op done: result=%h ov=%0b un=%0b dz=%0b lat=%0d",
                     result, overflow, underflow, div_by_zero, cyc - e.acc);
         end
      end
   end

   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] er,
                        input logic eo, input logic eu, input logic ed, input int lat);
      exp_t e;
      a = ia;
      b = ib;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.res = er; e.ov = eo; e.un = eu; e.dz = ed; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #2;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_result"}, result, 32'd0);
      chk({tag, "_flags"}, {29'd0, overflow, underflow, div_by_zero}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_zero("reset");
      rst = 1'b0;

      issue(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27); wait_drain();
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 0, 27); wait_drain();
      issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 0, 27); wait_drain();
      issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 1, 1);  wait_drain();
      issue(32'h7F000000, 32'h00800000, 32'h7F800000, 1, 0, 0, 27); wait_drain();
      issue(32'h00800000, 32'h7F000000, 32'h00000000, 0, 1, 0, 27); wait_drain();
      issue(32'h7F800000, 32'h3F800000, 32'h00000000, 0, 0, 0, 1);  wait_drain();
      issue(32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 0, 1);  wait_drain();
      issue(32'h00000000, 32'hC0000000, 32'h80000000, 0, 0, 0, 1);  wait_drain();
      issue(32'h3F800000, 32'hFF800000, 32'h00000000, 0, 0, 0, 1);  wait_drain();

      // start held high while busy with operands that would finish early if taken
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27);
      a = 32'h3F800000; b = 32'h00000000; start = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();

      // back-to-back: second accept lands in the done cycle of the first
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 0, 27);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("b2b_done_seen", 32'(done), 32'd1);
      #1;
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27);
      chk("b2b_done_drop", 32'(done), 32'd0);
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_drain();

      // reset in the middle of the division: no done, all outputs cleared
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_idle_zero("abort");
      repeat (40) @(posedge clk);
      #1;
      chk_idle_zero("abort_later");

      // start together with reset is lost
      rst = 1'b1; start = 1'b1; a = 32'h3F800000; b = 32'h00000000;
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", 32'(busy), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk_idle_zero("rst_start");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
